ex_stage_mc: RTL and testbench

Parametrised, multi-cycle execute stage for the core_lapido pipeline, sitting between the ID/EX register and the MEM stage. It performs single-cycle ALU operations and iterative unsigned multiply/divide/remainder. It stalls upstream with a valid/ready handshake and drives a registered EX/MEM output slot with its own valid/ready handshake. A flush input squashes in-flight work on branch/jump redirection.

---
 rtl/ex_stage_mc_pkg.sv | 32 +++
 rtl/ex_stage_mc_muldiv.sv | 90 +++++++++
 rtl/ex_stage_mc.sv | 153 +++++++++++++++
 tb/tb_ex_stage_mc.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_mc_pkg.sv
// Shared definitions for the core_lapido execute stage: function codes,
// FSM states and the iterative unit's operation select.
package ex_stage_mc_pkg;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_MUL  = 6'h18;
  localparam logic [5:0] FN_REMU = 6'h1A;
  localparam logic [5:0] FN_DIVU = 6'h1B;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIVU = 2'd1,
    MD_REMU = 2'd2
  } md_op_e;

  function automatic logic is_multi_cycle(input logic [5:0] funct);
    return (funct == FN_MUL) || (funct == FN_DIVU) || (funct == FN_REMU);
  endfunction

endpackage

// File: rtl/ex_stage_mc_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide/remainder,
// one iteration per clock, WIDTH iterations per operation.
module muldiv_iter
  import ex_stage_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  md_op_e           op_q;
  logic             running;
  logic [CNT_W-1:0] cnt;
  // acc: product accumulator or partial remainder; x_q: multiplicand or
  // dividend/quotient shift register; y_q: multiplier or divisor.
  logic [WIDTH-1:0] acc, x_q, y_q;
  logic [WIDTH-1:0] acc_nx, x_nx, y_nx;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             fits;

  assign done = running && (cnt == LAST_ITER);

  always_comb begin
    acc_nx = acc;
    x_nx   = x_q;
    y_nx   = y_q;
    rem_sh = {acc, x_q[WIDTH-1]};
    fits   = (rem_sh >= {1'b0, y_q});
    diff   = rem_sh[WIDTH-1:0] - y_q;
    if (op_q == MD_MUL) begin
      if (y_q[0]) acc_nx = acc + x_q;
      x_nx = x_q << 1;
      y_nx = y_q >> 1;
    end else if (fits) begin
      acc_nx = diff;
      x_nx   = {x_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_nx = rem_sh[WIDTH-1:0];
      x_nx   = {x_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= MD_MUL;
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (flush) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      op_q    <= op;
      running <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
      x_q     <= a;
      y_q     <= b;
    end else if (running) begin
      acc <= acc_nx;
      x_q <= x_nx;
      y_q <= y_nx;
      cnt <= cnt + CNT_W'(1);
      if (done) running <= 1'b0;
    end
  end

  always_comb begin
    case (op_q)
      MD_DIVU: result = x_q;
      MD_REMU: result = acc;
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/ex_stage_mc.sv
// Multi-cycle execute stage: single-cycle ALU, iterative mul/div, FSM and
// the registered EX/MEM output slot with valid/ready on both sides.
module ex_stage_mc
  import ex_stage_mc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            in_funct,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  input  logic [REG_ADDR_W-1:0] in_reg_dst,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_result,
  output logic [3:0]            out_flags,
  output logic [REG_ADDR_W-1:0] out_reg_dst,
  output logic [CTRL_W-1:0]     out_ctrl
);

  localparam int SHAMT_W = $clog2(WIDTH);

  ex_state_e state, state_nx;

  logic slot_free, accept, multi, md_start, load_single, load_md;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH-1:0] alu_result, md_result;
  logic             alu_c, alu_v, alu_known;
  logic [3:0]       alu_flags, md_flags;
  logic             md_done;
  md_op_e           md_op;
  logic [REG_ADDR_W-1:0] pend_dst;
  logic [CTRL_W-1:0]     pend_ctrl;

  assign slot_free   = !out_valid || out_ready;
  assign in_ready    = (state == ST_IDLE) && slot_free;
  assign multi       = is_multi_cycle(in_funct);
  assign accept      = in_valid && in_ready && !flush;
  assign md_start    = accept && multi;
  assign load_single = accept && !multi;
  assign load_md     = (state == ST_DONE) && slot_free && !flush;

  assign sum_ext  = {1'b0, in_a} + {1'b0, in_b};
  assign diff_ext = {1'b0, in_a} - {1'b0, in_b};

  // Carry on SUB means "no borrow"; unknown codes produce an all-zero slot.
  always_comb begin
    alu_result = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    alu_known  = 1'b1;
    case (in_funct)
      FN_ADD: begin
        alu_result = sum_ext[WIDTH-1:0];
        alu_c      = sum_ext[WIDTH];
        alu_v      = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                     (alu_result[WIDTH-1] != in_a[WIDTH-1]);
      end
      FN_SUB: begin
        alu_result = diff_ext[WIDTH-1:0];
        alu_c      = !diff_ext[WIDTH];
        alu_v      = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                     (alu_result[WIDTH-1] != in_a[WIDTH-1]);
      end
      FN_AND:  alu_result = in_a & in_b;
      FN_OR:   alu_result = in_a | in_b;
      FN_XOR:  alu_result = in_a ^ in_b;
      FN_SLL:  alu_result = in_a << in_b[SHAMT_W-1:0];
      FN_SRL:  alu_result = in_a >> in_b[SHAMT_W-1:0];
      default: alu_known  = 1'b0;
    endcase
    alu_flags = alu_known ?
                {alu_v, alu_c, alu_result[WIDTH-1], (alu_result == '0)} : 4'b0000;
  end

  assign md_op = (in_funct == FN_MUL)  ? MD_MUL  :
                 (in_funct == FN_DIVU) ? MD_DIVU : MD_REMU;

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .flush  (flush),
    .op     (md_op),
    .a      (in_a),
    .b      (in_b),
    .done   (md_done),
    .result (md_result)
  );

  assign md_flags = {2'b00, md_result[WIDTH-1], (md_result == '0)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (md_start) state_nx = ST_BUSY;
      ST_BUSY: if (md_done) state_nx = ST_DONE;
      ST_DONE: if (slot_free) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (flush) state_nx = ST_IDLE;
  end

  // Destination and control must survive the whole iteration period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_dst  <= '0;
      pend_ctrl <= '0;
    end else if (md_start) begin
      pend_dst  <= in_reg_dst;
      pend_ctrl <= in_ctrl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_flags   <= '0;
      out_reg_dst <= '0;
      out_ctrl    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_single) begin
      out_valid   <= 1'b1;
      out_result  <= alu_result;
      out_flags   <= alu_flags;
      out_reg_dst <= in_reg_dst;
      out_ctrl    <= in_ctrl;
    end else if (load_md) begin
      out_valid   <= 1'b1;
      out_result  <= md_result;
      out_flags   <= md_flags;
      out_reg_dst <= pend_dst;
      out_ctrl    <= pend_ctrl;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Bench for ex_stage_mc: directed scenarios plus randomized traffic compared
// every cycle against a transaction-level model.
module tb_ex_stage_mc;
  import ex_stage_mc_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  flags;
    logic [4:0]  dst;
    logic [7:0]  ctrl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_funct = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [4:0]  in_reg_dst = '0;
  logic [7:0]  in_ctrl = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic [4:0]  out_reg_dst;
  logic [7:0]  out_ctrl;

  int n_checks = 0;
  int n_pass = 0;
  bit cmp_en = 0;
  bit rand_ready = 0;

  logic        snap_ready, snap_valid;
  logic [31:0] snap_result;
  logic [3:0]  snap_flags;

  // Model state: m_wait counts edges left before a multi-cycle result may
  // move into the slot (1 = finished and waiting, 0 = idle).
  int   m_wait = 0;
  bit   m_valid = 0;
  exp_t m_slot = '0;
  exp_t m_pend = '0;

  logic [5:0] fn_tab [11] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLL,
                              FN_SRL, FN_MUL, FN_DIVU, FN_REMU, 6'h3F};

  ex_stage_mc #(.WIDTH(W), .REG_ADDR_W(5), .CTRL_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct(in_funct), .in_a(in_a), .in_b(in_b), .in_reg_dst(in_reg_dst),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
    .out_reg_dst(out_reg_dst), .out_ctrl(out_ctrl)
  );

  always #5 clk = ~clk;

  function automatic bit isMulti(input logic [5:0] f);
    return (f == FN_MUL) || (f == FN_DIVU) || (f == FN_REMU);
  endfunction

  // Expected result straight from arithmetic definitions of each operation.
  function automatic exp_t modelOp(input logic [5:0] f, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] d,
                                   input logic [7:0] c);
    exp_t e;
    longint sa, sb, s;
    longint unsigned ua, ub;
    logic [31:0] r;
    bit cy, ov, known;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = 64'(a); ub = 64'(b);
    r = '0; cy = 0; ov = 0; known = 1;
    case (f)
      FN_ADD:  begin r = a + b; cy = (ua + ub) > 64'hFFFF_FFFF; s = sa + sb;
                     ov = (s != longint'($signed(r))); end
      FN_SUB:  begin r = a - b; cy = (a >= b); s = sa - sb;
                     ov = (s != longint'($signed(r))); end
      FN_AND:  r = a & b;
      FN_OR:   r = a | b;
      FN_XOR:  r = a ^ b;
      FN_SLL:  r = a << (b % 32);
      FN_SRL:  r = a >> (b % 32);
      FN_MUL:  r = 32'(ua * ub);
      FN_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      FN_REMU: r = (b == 0) ? a : a % b;
      default: known = 0;
    endcase
    e.result = r;
    e.flags  = known ? {ov, cy, r[31], (r == 0)} : 4'b0000;
    e.dst    = d;
    e.ctrl   = c;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
  endtask

  task automatic reportTimeout(input string name);
    n_checks++;
    $display("[TB] FAIL %s: got timeout, want completion", name);
  endtask

  task automatic takeSnap();
    snap_ready  = in_ready;
    snap_valid  = out_valid;
    snap_result = out_result;
    snap_flags  = out_flags;
  endtask

  // Present one instruction from the next falling edge and hold it until the
  // rising edge at which it is accepted.
  task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] d,
                               input logic [7:0] c);
    int waited = 0;
    bit done = 0;
    @(negedge clk);
    in_valid = 1; in_funct = f; in_a = a; in_b = b;
    in_reg_dst = d; in_ctrl = c; flush = 0;
    while (!done) begin
      #1;
      takeSnap();
      if (in_ready) done = 1;
      else begin
        waited++;
        if (waited > 200) begin
          reportTimeout("accept");
          done = 1;
        end else @(negedge clk);
      end
    end
    @(posedge clk);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 0; flush = 0;
      #1;
      takeSnap();
    end
  endtask

  task automatic waitValid();
    int k = 0;
    do begin
      idleCycles(1);
      k++;
    end while (!snap_valid && k < 100);
    if (!snap_valid) reportTimeout("result_valid");
  endtask

  task automatic doFlush();
    @(negedge clk);
    flush = 1;
    in_valid = 1'($urandom_range(1));
    in_funct = fn_tab[$urandom_range(10)];
    in_a = $urandom; in_b = $urandom;
    @(negedge clk);
    flush = 0; in_valid = 0;
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(3))
      0:       return 32'($urandom_range(15));
      1:       return 32'h7FFF_FFFF + 32'($urandom_range(2));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) if (rand_ready) out_ready = ($urandom_range(3) != 0);

  always @(posedge clk or posedge rst) begin : model
    exp_t r;
    bit free, rdy, load;
    if (rst) begin
      m_wait  <= 0;
      m_valid <= 0;
    end else begin
      free = !m_valid || out_ready;
      rdy  = (m_wait == 0) && free;
      load = 0;
      if (flush) begin
        m_wait  <= 0;
        m_valid <= 0;
      end else begin
        if (m_wait == 1 && free) begin
          m_slot <= m_pend;
          load = 1;
          m_wait <= 0;
        end else if (m_wait > 1) begin
          m_wait <= m_wait - 1;
        end else if (m_wait == 0 && in_valid && rdy) begin
          r = modelOp(in_funct, in_a, in_b, in_reg_dst, in_ctrl);
          if (isMulti(in_funct)) begin
            m_pend <= r;
            m_wait <= W + 1;
          end else begin
            m_slot <= r;
            load = 1;
          end
        end
        if (load) m_valid <= 1;
        else if (out_ready) m_valid <= 0;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst && cmp_en) begin
      checkOutput("in_ready", 64'(in_ready), 64'((m_wait == 0) && (!m_valid || out_ready)));
      checkOutput("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        checkOutput("out_result", 64'(out_result), 64'(m_slot.result));
        checkOutput("out_flags", 64'(out_flags), 64'(m_slot.flags));
        checkOutput("out_reg_dst", 64'(out_reg_dst), 64'(m_slot.dst));
        checkOutput("out_ctrl", 64'(out_ctrl), 64'(m_slot.ctrl));
      end
    end
  end

  initial begin
    int low;
    exp_t e;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_result", 64'(out_result), 64'd0);
    checkOutput("reset_flags", 64'(out_flags), 64'd0);
    checkOutput("reset_reg_dst", 64'(out_reg_dst), 64'd0);
    checkOutput("reset_ctrl", 64'(out_ctrl), 64'd0);
    cmp_en = 1;

    e = modelOp(FN_MUL, 32'd1234, 32'd5678, 5'd0, 8'd0);
    checkOutput("model_mul", 64'(e.result), 64'd7006652);
    e = modelOp(FN_SUB, 32'd3, 32'd5, 5'd0, 8'd0);
    checkOutput("model_sub_borrow", 64'(e.flags), 64'b0010);

    applyStimulus(FN_ADD, 32'h7FFF_FFFF, 32'd1, 5'd3, 8'hA5);
    idleCycles(1);
    checkOutput("add_ovf_valid", 64'(snap_valid), 64'd1);
    checkOutput("add_ovf_result", 64'(snap_result), 64'h8000_0000);
    checkOutput("add_ovf_flags", 64'(snap_flags), 64'b1010);

    applyStimulus(FN_SUB, 32'd5, 32'd5, 5'd4, 8'h11);
    applyStimulus(FN_XOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'd5, 8'h22);
    checkOutput("sub_result", 64'(snap_result), 64'd0);
    checkOutput("sub_flags", 64'(snap_flags), 64'b0101);
    checkOutput("b2b_in_ready", 64'(snap_ready), 64'd1);
    idleCycles(1);
    checkOutput("xor_result", 64'(snap_result), 64'hFFFF_FFFF);
    checkOutput("xor_flags", 64'(snap_flags), 64'b0010);

    applyStimulus(FN_MUL, 32'd1234, 32'd5678, 5'd6, 8'h33);
    low = 0;
    do begin
      idleCycles(1);
      if (!snap_ready) low++;
    end while (!snap_ready && low < 100);
    checkOutput("mul_busy_cycles", 64'(low), 64'd33);
    checkOutput("mul_valid", 64'(snap_valid), 64'd1);
    checkOutput("mul_result", 64'(snap_result), 64'd7006652);
    checkOutput("mul_flags", 64'(snap_flags), 64'd0);

    applyStimulus(FN_DIVU, 32'd100, 32'd7, 5'd7, 8'h44);
    waitValid();
    checkOutput("divu_result", 64'(snap_result), 64'd14);
    applyStimulus(FN_REMU, 32'd100, 32'd7, 5'd8, 8'h55);
    waitValid();
    checkOutput("remu_result", 64'(snap_result), 64'd2);
    applyStimulus(FN_DIVU, 32'd9, 32'd0, 5'd9, 8'h66);
    waitValid();
    checkOutput("div0_result", 64'(snap_result), 64'hFFFF_FFFF);
    applyStimulus(FN_REMU, 32'd9, 32'd0, 5'd9, 8'h66);
    waitValid();
    checkOutput("rem0_result", 64'(snap_result), 64'd9);

    idleCycles(1);
    out_ready = 0;
    applyStimulus(FN_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd10, 8'h77);
    idleCycles(1);
    checkOutput("stall_in_ready", 64'(snap_ready), 64'd0);
    idleCycles(1);
    checkOutput("stall_valid", 64'(snap_valid), 64'd1);
    checkOutput("stall_result", 64'(snap_result), 64'h0F00_0F00);
    @(negedge clk);
    out_ready = 1; in_valid = 1; in_funct = FN_OR;
    in_a = 32'h12; in_b = 32'h21; in_reg_dst = 5'd11; in_ctrl = 8'h88;
    #1;
    takeSnap();
    checkOutput("drain_in_ready", 64'(snap_ready), 64'd1);
    @(posedge clk);
    idleCycles(1);
    checkOutput("drain_next_result", 64'(snap_result), 64'h33);

    applyStimulus(FN_MUL, 32'd1234, 32'd5678, 5'd12, 8'h99);
    idleCycles(9);
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    #1;
    takeSnap();
    checkOutput("flush_out_valid", 64'(snap_valid), 64'd0);
    checkOutput("flush_in_ready", 64'(snap_ready), 64'd1);
    applyStimulus(FN_ADD, 32'd2, 32'd3, 5'd13, 8'hAA);
    idleCycles(1);
    checkOutput("post_flush_add", 64'(snap_result), 64'd5);

    applyStimulus(FN_DIVU, 32'hDEAD_BEEF, 32'd3, 5'd14, 8'hBB);
    idleCycles(5);
    @(negedge clk);
    rst = 1;
    #1;
    checkOutput("async_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("async_rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("async_rst_result", 64'(out_result), 64'd0);
    @(negedge clk);
    rst = 0;

    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(99);
      if (r < 4) doFlush();
      else if (r < 14) idleCycles(1 + $urandom_range(2));
      else applyStimulus(fn_tab[$urandom_range(10)], randOperand(), randOperand(),
                         5'($urandom), 8'($urandom));
    end
    rand_ready = 0;
    @(negedge clk);
    out_ready = 1;
    idleCycles(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
